sample_u_ctrl: RTL and testbench
================================

# sample_u_ctrl

Job controller for the uniform-u sampler datapath. On `start` it latches the sampling configuration, pulls 48-bit words from the XOF stream with a valid/ready handshake, and feeds them to the sampler one per cycle. It collects the sampler's 2-cycle-latency outputs and writes packed coefficients to the polynomial RAM with a linear address. It signals completion once every coefficient of every requested polynomial is written.

## Interface
- `N`, 512, coefficients per polynomial; power of two.
- `MAXP`, 8, maximum polynomials per job.
- `AW`, 12, write address width; must satisfy 2^AW ≥ MAXP·N.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  job request pulse; sampled only in IDLE.
- `cfg_u`  in  6  sample width u.
- `cfg_wide`  in  1  1: one 41-bit-class coefficient per XOF word; 0: two 8-bit-class coefficients per word.
- `cfg_npoly`  in  4  polynomials in job, 1..MAXP.
- `xof_data`  in  48  XOF word.
- `xof_valid`  in  1  XOF word available.
- `xof_ready`  out  1  controller accepts word this cycle.
- `smp_u`  out  6  sampler u, held for whole job.
- `smp_mode`  out  1  sampler mode, held for whole job.
- `smp_din`  out  48  registered XOF word to sampler.
- `smp_din_flag`  out  1  `smp_din` valid.
- `smp_flag`  in  1  sampler result valid (2 cycles after `smp_din_flag`).
- `smp_d3`, `smp_d4`  in  25 each  sampler results.
- `wr_en`  out  1  RAM write strobe.
- `wr_addr`  out  AW  RAM word address.
- `wr_data`  out  50  `{smp_d3, smp_d4}`.
- `busy`  out  1  job in progress.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse: rejected configuration.

## Operation
- Reset: state IDLE; `xof_ready`, `smp_din_flag`, `wr_en`, `busy`, `done`, `err` = 0; `smp_din`, `wr_addr`, `wr_data`, counters = 0; `smp_u`, `smp_mode` = 0.
- Words per polynomial WPP = N when `cfg_wide`, N/2 otherwise. TOTAL = `cfg_npoly`·WPP, computed at `start`. Counter widths: AW+1 bits.
- Legal config: `cfg_npoly` in 1..MAXP; u in 1..8 (narrow) or 1..41 (wide). Illegal config at `start`: `err` pulses the next cycle, state stays IDLE, and no XOF words are consumed.
- States:
  - IDLE: on legal `start`, latch `cfg_u`→`smp_u` and `cfg_wide`→`smp_mode`, clear counters, set `busy`, go to SETUP.
  - SETUP: exactly one cycle. Lets the sampler's registered mask/mid settle from the new u. `xof_ready` = 0. Go to RUN.
  - RUN: `xof_ready` = 1 while issue count < TOTAL. A handshake (`xof_valid & xof_ready`) registers `xof_data` into `smp_din`, sets `smp_din_flag` for one cycle, and increments the issue count. When the issue count reaches TOTAL, go to DRAIN.
  - DRAIN: `xof_ready` = 0. Wait until write count = TOTAL.
  - DONE: one cycle. `done` = 1, `busy` drops the same cycle, then IDLE.
- Write path, independent of state: each cycle with `smp_flag` = 1 registers `wr_en` = 1, `wr_data` = `{smp_d3,smp_d4}`, and `wr_addr` = write count, then increments the write count. Polynomial p occupies addresses p·WPP .. p·WPP+WPP−1. In narrow mode the upper word packs the even coefficient (d3, from `Din[15:8]`) and the lower word packs the odd one (d4); zero extension is the sampler's responsibility.
- `xof_valid` gaps are legal at any point; the issue stream simply stalls. No state advance depends on them except the issue count.
- `start` while `busy`: ignored.
- `smp_u`/`smp_mode` must not change while `busy`.
- `rst` mid-job: the controller returns to IDLE next cycle. Any in-flight sampler results arriving afterward are not written, because `wr_en` is forced 0 in IDLE.

## Timing
- `start` at cycle 0 → SETUP at 1, first `xof_ready` at 2.
- Handshake at cycle t → `smp_din_flag` at t+1 → `smp_flag` at t+3 → `wr_en` at t+4.
- With `xof_valid` held high: one word per cycle, no bubbles. Last handshake at cycle 1+TOTAL, `done` at TOTAL+6, `busy` low from the same cycle.
- Back-to-back jobs: `start` accepted the cycle after `done`.

## Test plan
- Narrow, u=4, npoly=1, `xof_valid` constant: 256 handshakes on cycles 2..257. 256 writes on addresses 0..255 with `wr_data` equal to `{smp_d3,smp_d4}`. `done` at cycle 262, exactly one pulse.
- Wide, u=41, npoly=2: 1024 handshakes and writes on addresses 0..1023. `smp_mode`=1 and `smp_u`=41 stay stable throughout. `done` occurs once.
- Random `xof_valid` (50% duty), narrow, npoly=3: exactly 768 writes with contiguous addresses, no gaps or duplicates. `xof_ready` never high after the 768th handshake.
- Illegal configs (npoly=0; npoly=9; narrow u=9; wide u=0): `err` pulses one cycle, `busy` stays 0, `xof_ready` stays 0.
- `start` pulsed while busy: ignored, and the job result is identical to the undisturbed run. `start` the cycle after `done`: new job begins with `wr_addr` restarting at 0.
- `rst` asserted after 100 handshakes: next cycle all outputs take reset values. No `wr_en` for the two trailing sampler results. A fresh job afterward completes normally.

Source files
------------

// File: rtl/sample_u_ctrl.sv
// sample_u_ctrl: job controller feeding XOF words to the uniform-u sampler
// and writing its packed coefficients to polynomial RAM at linear addresses.
module sample_u_ctrl #(
    parameter int N    = 512,
    parameter int MAXP = 8,
    parameter int AW   = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [5:0]    cfg_u,
    input  logic          cfg_wide,
    input  logic [3:0]    cfg_npoly,
    input  logic [47:0]   xof_data,
    input  logic          xof_valid,
    output logic          xof_ready,
    output logic [5:0]    smp_u,
    output logic          smp_mode,
    output logic [47:0]   smp_din,
    output logic          smp_din_flag,
    input  logic          smp_flag,
    input  logic [24:0]   smp_d3,
    input  logic [24:0]   smp_d4,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [49:0]   wr_data,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam int CW = AW + 1;
    localparam int LG = $clog2(N);

    typedef enum logic [2:0] {IDLE, SETUP, RUN, DRAIN, FIN} state_t;
    state_t state;

    logic [CW-1:0] total, icnt, wcnt, total_nxt;
    logic          legal, hs, wr_ok;

    assign legal = cfg_npoly != 4'd0 && cfg_npoly <= 4'(MAXP) && cfg_u != 6'd0 &&
                   cfg_u <= (cfg_wide ? 6'd41 : 6'd8);
    assign hs        = xof_valid && xof_ready;
    assign total_nxt = CW'(cfg_npoly) << (cfg_wide ? LG : LG - 1);
    // results trickling in after an abort are dropped once we are back in IDLE
    assign wr_ok     = smp_flag && state != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            xof_ready    <= 1'b0;
            smp_u        <= 6'd0;
            smp_mode     <= 1'b0;
            smp_din      <= 48'd0;
            smp_din_flag <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= 50'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            total        <= '0;
            icnt         <= '0;
            wcnt         <= '0;
        end else begin
            done         <= 1'b0;
            err          <= 1'b0;
            smp_din_flag <= hs;
            wr_en        <= wr_ok;
            if (hs) begin
                smp_din <= xof_data;
                icnt    <= icnt + CW'(1);
            end
            if (wr_ok) begin
                wr_data <= {smp_d3, smp_d4};
                wr_addr <= wcnt[AW-1:0];
                wcnt    <= wcnt + CW'(1);
            end
            case (state)
                IDLE: begin
                    if (start && legal) begin
                        smp_u    <= cfg_u;
                        smp_mode <= cfg_wide;
                        total    <= total_nxt;
                        icnt     <= '0;
                        wcnt     <= '0;
                        busy     <= 1'b1;
                        state    <= SETUP;
                    end else if (start) begin
                        err <= 1'b1;
                    end
                end
                SETUP: begin
                    xof_ready <= 1'b1;
                    state     <= RUN;
                end
                RUN: begin
                    if (hs && icnt + CW'(1) == total) begin
                        xof_ready <= 1'b0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (wcnt == total) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= FIN;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sample_u_ctrl.sv
// tb_sample_u_ctrl: scoreboard bench for sample_u_ctrl with a 2-cycle sampler stand-in.
module tb_sample_u_ctrl;
    localparam int N    = 512;
    localparam int MAXP = 8;
    localparam int AW   = 12;
    localparam logic [24:0] K = 25'h0ABCDEF;

    logic          clk = 0, rst = 1, start = 0;
    logic [5:0]    cfg_u = 0;
    logic          cfg_wide = 0;
    logic [3:0]    cfg_npoly = 0;
    logic [47:0]   xof_data = 0;
    logic          xof_valid = 0;
    logic          xof_ready, smp_mode, smp_din_flag, wr_en, busy, done, err;
    logic [5:0]    smp_u;
    logic [47:0]   smp_din;
    logic          smp_flag = 0;
    logic [24:0]   smp_d3 = 0, smp_d4 = 0;
    logic [AW-1:0] wr_addr;
    logic [49:0]   wr_data;

    sample_u_ctrl #(.N(N), .MAXP(MAXP), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_u(cfg_u), .cfg_wide(cfg_wide),
        .cfg_npoly(cfg_npoly), .xof_data(xof_data), .xof_valid(xof_valid),
        .xof_ready(xof_ready), .smp_u(smp_u), .smp_mode(smp_mode), .smp_din(smp_din),
        .smp_din_flag(smp_din_flag), .smp_flag(smp_flag), .smp_d3(smp_d3), .smp_d4(smp_d4),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // sampler stand-in: two register stages between din and result
    logic        p1f = 0;
    logic [47:0] p1d = 0;
    always @(posedge clk) begin
        p1f      <= smp_din_flag;
        p1d      <= smp_din;
        smp_flag <= p1f;
        smp_d3   <= p1d[24:0] ^ K;
        smp_d4   <= p1d[47:23];
    end

    logic [49:0] sb[$];
    logic [49:0] e_sb;
    logic [5:0]  exp_u = 0;
    logic        exp_mode = 0;
    int ea = 0, hs_n = 0, wr_n = 0, done_n = 0, bad_ready = 0, bad_cfg = 0;
    int first_hs = -1, done_cyc = -1, job_total = 0;
    int tests = 0, fails = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (xof_ready && hs_n >= job_total) bad_ready++;
            if (xof_valid && xof_ready) begin
                if (hs_n == 0) first_hs = cyc;
                hs_n++;
                sb.push_back({xof_data[24:0] ^ K, xof_data[47:23]});
            end
            if (wr_en) begin
                chk("sb_nonempty", 64'(sb.size() != 0), 1);
                e_sb = 50'h0;
                if (sb.size() != 0) e_sb = sb.pop_front();
                chk("wr_data", wr_data, e_sb);
                chk("wr_addr", wr_addr, 64'(ea));
                ea++;
                wr_n++;
            end
            if (done) begin
                done_n++;
                done_cyc = cyc;
                chk("busy_at_done", busy, 0);
            end
            if (busy && (smp_u !== exp_u || smp_mode !== exp_mode)) bad_cfg++;
        end
    end

    task automatic arm(input logic w, input logic [5:0] u, input logic [3:0] np);
        job_total = (w ? N : N / 2) * int'(np);
        hs_n = 0; wr_n = 0; ea = 0; done_cyc = -1; first_hs = -1;
        exp_u = u; exp_mode = w; bad_ready = 0; bad_cfg = 0;
        start = 1; cfg_wide = w; cfg_u = u; cfg_npoly = np;
    endtask

    // entered and left at #1 after a rising edge, so jobs can run back to back
    task automatic run_job(input logic w, input logic [5:0] u, input logic [3:0] np,
                           input bit rv, input bit mid);
        int t0;
        int budget;
        arm(w, u, np);
        t0 = cyc;
        budget = 8 * job_total + 100;
        for (int i = 0; i < budget && done_cyc < 0; i++) begin
            @(posedge clk); #1;
            start = 0;
            if (mid && i == 40) begin
                start = 1; cfg_u = 6'd3; cfg_wide = ~w; cfg_npoly = 4'd5;
            end
            xof_valid = rv ? 1'($urandom_range(0, 1)) : 1'b1;
            xof_data = 48'({$urandom(), $urandom()});
        end
        start = 0;
        xof_valid = 0;
        chk("done_seen", 64'(done_cyc >= 0), 1);
        if (!rv) begin
            chk("done_latency", 64'(done_cyc - t0), 64'(job_total + 6));
            chk("first_hs", 64'(first_hs - t0), 2);
        end
        chk("hs_count", 64'(hs_n), 64'(job_total));
        chk("wr_count", 64'(wr_n), 64'(job_total));
        chk("sb_empty", 64'(sb.size()), 0);
        chk("ready_after_last", 64'(bad_ready), 0);
        chk("cfg_stable", 64'(bad_cfg), 0);
        chk("busy_after_done", busy, 0);
    endtask

    task automatic bad_job(input logic w, input logic [5:0] u, input logic [3:0] np);
        hs_n = 0;
        start = 1; cfg_wide = w; cfg_u = u; cfg_npoly = np; xof_valid = 1;
        @(posedge clk); #1;
        start = 0;
        @(negedge clk);
        chk("err_pulse", err, 1);
        chk("err_busy", busy, 0);
        chk("err_ready", xof_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("err_once", err, 0);
        chk("err_idle", {busy, xof_ready}, 0);
        chk("err_no_hs", 64'(hs_n), 0);
        @(posedge clk); #1;
        xof_valid = 0;
    endtask

    task automatic abort_job();
        arm(1'b0, 6'd4, 4'd1);
        for (int i = 0; i < 400 && hs_n < 100; i++) begin
            @(posedge clk); #1;
            start = 0;
            xof_valid = 1;
            xof_data = 48'({$urandom(), $urandom()});
        end
        chk("abort_reached", 64'(hs_n), 100);
        rst = 1;
        xof_valid = 0;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("rst_ctl", {xof_ready, smp_din_flag, wr_en, busy, done, err, smp_u, smp_mode, wr_addr}, 0);
        chk("rst_din", smp_din, 0);
        chk("rst_wdata", wr_data, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_wr_after_rst", wr_en, 0);
        end
        sb.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctl", {xof_ready, smp_din_flag, wr_en, busy, done, err, smp_u, smp_mode, wr_addr}, 0);
        chk("reset_data", {smp_din, wr_data[15:0]}, 0);
        @(posedge clk); #1;
        rst = 0;
        run_job(1'b0, 6'd4, 4'd1, 1'b0, 1'b0);
        run_job(1'b1, 6'd41, 4'd2, 1'b0, 1'b0);
        run_job(1'b0, 6'd5, 4'd3, 1'b1, 1'b0);
        bad_job(1'b0, 6'd4, 4'd0);
        bad_job(1'b0, 6'd4, 4'd9);
        bad_job(1'b0, 6'd9, 4'd1);
        bad_job(1'b1, 6'd0, 4'd1);
        run_job(1'b0, 6'd8, 4'd1, 1'b0, 1'b1);
        run_job(1'b1, 6'd1, 4'd1, 1'b0, 1'b0);
        abort_job();
        run_job(1'b0, 6'd2, 4'd2, 1'b0, 1'b0);
        chk("done_pulses", 64'(done_n), 6);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
